// File: rtl/imem_loader.sv
// Boot loader: assembles a byte stream into big-endian words, writes them to
// instruction memory, and holds the processor in reset until the checksum verifies.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {IDLE, LEN, BYTE, WRITE, CHK, DONE, ERR} state_t;

  state_t      state;
  logic [8:0]  remaining;
  logic [1:0]  index;
  logic [7:0]  checksum;
  logic        transfer;

  assign transfer = in_valid && in_ready;

  // in_ready is registered alongside the state so it never depends on in_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cpu_reset  <= 1'b1;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= ADDR_W'(BASE_ADDR);
      imem_wdata <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      index      <= 2'd0;
      checksum   <= 8'd0;
      remaining  <= 9'd0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state     <= LEN;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_reset <= 1'b1;
            imem_addr <= ADDR_W'(BASE_ADDR);
            checksum  <= 8'd0;
          end
        end
        LEN: begin
          if (transfer) begin
            remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            index     <= 2'd0;
            state     <= BYTE;
          end
        end
        BYTE: begin
          if (transfer) begin
            case (index)
              2'd0: imem_wdata[31:24] <= in_data;
              2'd1: imem_wdata[23:16] <= in_data;
              2'd2: imem_wdata[15:8]  <= in_data;
              default: imem_wdata[7:0] <= in_data;
            endcase
            checksum <= checksum ^ in_data;
            index    <= index + 2'd1;
            if (index == 2'd3) begin
              state    <= WRITE;
              in_ready <= 1'b0;
              imem_we  <= 1'b1;
            end
          end
        end
        WRITE: begin
          imem_we   <= 1'b0;
          imem_addr <= imem_addr + 1'b1;
          remaining <= remaining - 9'd1;
          index     <= 2'd0;
          in_ready  <= 1'b1;
          state     <= (remaining == 9'd1) ? CHK : BYTE;
        end
        CHK: begin
          if (transfer) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == checksum) begin
              state     <= DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          imem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: random program images with optional valid gaps.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;

  logic [39:0] exp_q[$];
  logic [31:0] load_words[$];

  imem_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every write strobe must match the next expected (addr, data) pair.
  always @(negedge clk) begin
    if (!reset && imem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", imem_addr, imem_wdata);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          errors++;
          $display("[TB] FAIL write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                   imem_addr, imem_wdata, e[39:32], e[31:0]);
        end
      end
      checkOutput("in_ready_during_write", {31'd0, in_ready}, 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int cyc;
    cyc = 0;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready) begin
      @(negedge clk);
      cyc++;
      if (cyc > 200) begin
        checkOutput("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends load_words as one image; the expected writes come from word position alone.
  task automatic applyStimulus(input bit bad, input bit gaps, input bit mid_start);
    int n;
    logic [7:0] cks;
    logic [31:0] w;
    n = load_words.size();
    for (int k = 0; k < n; k++) exp_q.push_back({8'(k), load_words[k]});
    pulse_start();
    send_byte(8'(n), gaps);
    cks = 8'h00;
    for (int k = 0; k < n; k++) begin
      w = load_words[k];
      for (int b = 0; b < 4; b++) begin
        cks ^= w[31-8*b -: 8];
        if (mid_start && k == 1 && b == 1) start = 1'b1;
        send_byte(w[31-8*b -: 8], gaps);
        start = 1'b0;
      end
    end
    checkOutput("done_before_checksum", {31'd0, done}, 32'd0);
    send_byte(bad ? (cks ^ 8'h01) : cks, gaps);
    checkOutput("done", {31'd0, done}, {31'd0, !bad});
    checkOutput("error", {31'd0, error}, {31'd0, bad});
    checkOutput("cpu_reset", {31'd0, cpu_reset}, {31'd0, bad});
    checkOutput("busy_after", {31'd0, busy}, 32'd0);
    checkOutput("pending_writes", exp_q.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #2;
    checkOutput("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_imem_we", {31'd0, imem_we}, 32'd0);
    checkOutput("rst_imem_addr", {24'd0, imem_addr}, 32'd0);
    checkOutput("rst_imem_wdata", imem_wdata, 32'd0);
    checkOutput("rst_flags", {29'd0, busy, done, error}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] nominal load");
    load_words = '{32'h20080005, 32'h8C090004};
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] nominal load with valid gaps");
    applyStimulus(1'b0, 1'b1, 1'b0);

    $display("[TB] bad checksum then good reload");
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);

    $display("[TB] start pulsed while busy");
    load_words = '{32'h11111111, 32'h22222222, 32'h33333333};
    applyStimulus(1'b0, 1'b0, 1'b1);

    $display("[TB] random images");
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 8);
      load_words.delete();
      for (int k = 0; k < n; k++) load_words.push_back($urandom);
      applyStimulus(r[0], 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] count byte 0 means 256 words");
    load_words.delete();
    for (int k = 0; k < 256; k++) load_words.push_back(32'(k));
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("addr_wrapped", {24'd0, imem_addr}, 32'd0);

    $display("[TB] reset in the middle of a load");
    exp_q.push_back({8'd0, 32'hCAFEBABE});
    pulse_start();
    send_byte(8'd2, 1'b0);
    send_byte(8'hCA, 1'b0); send_byte(8'hFE, 1'b0); send_byte(8'hBA, 1'b0); send_byte(8'hBE, 1'b0);
    send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0);
    checkOutput("busy_mid_load", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("midrst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_imem_we", {31'd0, imem_we}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b1; in_data = 8'h56;
    repeat (20) @(negedge clk);
    in_valid = 1'b0;
    checkOutput("idle_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("idle_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    checkOutput("idle_pending_writes", exp_q.size(), 32'd0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
